// File: rtl/cms_pix28_package.sv
// Shared types and widths for the cms_pix28 ip2 test machines.
package cms_pix28_package;

    localparam int unsigned PhaseW     = 6;
    localparam int unsigned LoopCountW = 16;
    localparam int unsigned TimeoutW   = 20;

    typedef enum logic [2:0] {
        IDLE_LC      = 3'd0,
        ALIGN_LC     = 3'd1,
        TRIG_LC      = 3'd2,
        WAIT_DONE_LC = 3'd3,
        GAP_LC       = 3'd4,
        DONE_LC      = 3'd5,
        ERROR_LC     = 3'd6
    } state_t_sm_ip2_loop_ctrl;

endpackage

// File: rtl/ip2_test_loop_ctrl.sv
// Loop controller for an ip2 test machine: launches the test on a fixed clk_counter phase,
// counts completions, spaces iterations by a gap and flags a missing completion as a timeout.
module ip2_test_loop_ctrl
    import cms_pix28_package::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [PhaseW-1:0]       clk_counter,
    input  logic                    start,
    input  logic                    abort,
    input  logic [PhaseW-1:0]       trig_phase,
    input  logic [LoopCountW-1:0]   loop_count_max,
    input  logic [LoopCountW-1:0]   loop_gap,
    input  logic [TimeoutW-1:0]     timeout_max,
    input  logic                    test_status_done,
    output logic                    test_enable_re,
    output logic                    loop_busy,
    output logic [LoopCountW-1:0]   loop_count,
    output logic                    loop_status_done,
    output logic                    loop_status_timeout,
    output state_t_sm_ip2_loop_ctrl sm_loop_state
);

    state_t_sm_ip2_loop_ctrl state_q, state_d;

    logic [TimeoutW-1:0]   tmo_q;
    logic [LoopCountW-1:0] gap_q;
    logic [LoopCountW-1:0] count_inc;
    logic                  done_d;
    logic                  done_re;
    logic                  clear;
    logic                  start_ok;
    logic                  phase_hit;
    logic                  tmo_hit;
    logic                  gap_hit;
    logic                  run_last;
    logic                  count_en;

    assign clear     = reset | ~enable;
    // A done level already high at launch has done_d set, so it never produces an edge.
    assign done_re   = test_status_done & ~done_d;
    assign count_inc = loop_count + 1'b1;
    assign start_ok  = (state_q == IDLE_LC) & start & ~abort;
    assign phase_hit = (clk_counter == trig_phase);
    assign tmo_hit   = (tmo_q == timeout_max);
    assign gap_hit   = (gap_q == loop_gap);
    assign run_last  = (loop_count_max != '0) & (count_inc == loop_count_max);
    assign count_en  = (state_q == WAIT_DONE_LC) & done_re & ~abort;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE_LC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE_LC;
        end else begin
            unique case (state_q)
                IDLE_LC:      if (start) state_d = ALIGN_LC;
                ALIGN_LC:     if (phase_hit) state_d = TRIG_LC;
                TRIG_LC:      state_d = WAIT_DONE_LC;
                // Completion takes priority over a timeout reached on the same cycle.
                WAIT_DONE_LC: begin
                    if (done_re) begin
                        state_d = run_last ? DONE_LC : GAP_LC;
                    end else if (tmo_hit) begin
                        state_d = ERROR_LC;
                    end
                end
                GAP_LC:       if (gap_hit) state_d = ALIGN_LC;
                DONE_LC:      state_d = IDLE_LC;
                ERROR_LC:     state_d = ERROR_LC;
                default:      state_d = IDLE_LC;
            endcase
        end
    end

    always_comb begin
        sm_loop_state = state_q;
        loop_busy     = (state_q == ALIGN_LC) | (state_q == TRIG_LC) |
                        (state_q == WAIT_DONE_LC) | (state_q == GAP_LC);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            done_d              <= 1'b0;
            tmo_q               <= '0;
            gap_q               <= '0;
            test_enable_re      <= 1'b0;
            loop_count          <= '0;
            loop_status_done    <= 1'b0;
            loop_status_timeout <= 1'b0;
        end else begin
            done_d         <= test_status_done;
            tmo_q          <= (state_q == WAIT_DONE_LC) ? tmo_q + 1'b1 : '0;
            gap_q          <= (state_q == GAP_LC) ? gap_q + 1'b1 : '0;
            // Registered so the pulse lines up exactly with the TRIG_LC state cycle.
            test_enable_re <= (state_d == TRIG_LC);
            if (start_ok) begin
                loop_count          <= '0;
                loop_status_done    <= 1'b0;
                loop_status_timeout <= 1'b0;
            end
            if (count_en) begin
                loop_count <= count_inc;
            end
            if (state_d == DONE_LC) begin
                loop_status_done <= 1'b1;
            end
            if ((state_q == WAIT_DONE_LC) && (state_d == ERROR_LC)) begin
                loop_status_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ip2_test_loop_ctrl.sv
// Bench for ip2_test_loop_ctrl: a responding test-machine model plus launch times predicted
// arithmetically from phase, done delay, gap and timeout.
module tb_ip2_test_loop_ctrl;
    import cms_pix28_package::*;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    enable;
    logic [5:0]              clk_counter;
    logic                    start;
    logic                    abort;
    logic [5:0]              trig_phase;
    logic [15:0]             loop_count_max;
    logic [15:0]             loop_gap;
    logic [19:0]             timeout_max;
    logic                    test_status_done;
    logic                    test_enable_re;
    logic                    loop_busy;
    logic [15:0]             loop_count;
    logic                    loop_status_done;
    logic                    loop_status_timeout;
    state_t_sm_ip2_loop_ctrl sm_loop_state;

    always #5 clk = ~clk;

    ip2_test_loop_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .clk_counter         (clk_counter),
        .start               (start),
        .abort               (abort),
        .trig_phase          (trig_phase),
        .loop_count_max      (loop_count_max),
        .loop_gap            (loop_gap),
        .timeout_max         (timeout_max),
        .test_status_done    (test_status_done),
        .test_enable_re      (test_enable_re),
        .loop_busy           (loop_busy),
        .loop_count          (loop_count),
        .loop_status_done    (loop_status_done),
        .loop_status_timeout (loop_status_timeout),
        .sm_loop_state       (sm_loop_state)
    );

    int   ncmp = 0;
    int   nfail = 0;
    int   edge_n = 0;       // index of the last posedge; edge n samples clk_counter == n % 64
    int   pulses[$];        // edges after which test_enable_re was seen high
    int   done_edge;
    int   err_edge;
    bit   resp_en;
    bit   armed;
    bit   busy_start;
    int   drop_dly;
    int   resp_dly;
    int   drop_at;
    int   rise_at;
    logic tsd;
    int   exp_q[$];
    int   exp_end;
    bit   exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_phase(input int from, input int trig);
        return from + (((trig - (from % 64)) % 64) + 64) % 64;
    endfunction

    // Launch edges of a run started at edge s; a done arriving d edges after launch.
    task automatic predict(input int s, input int m, input int g, input int trig,
                           input int d, input int t, input bit resp, input int lim);
        int e;
        int w;
        exp_q.delete();
        exp_end = -1;
        exp_err = 1'b0;
        e = next_phase(s + 1, trig);
        for (int i = 1; i <= lim; i++) begin
            exp_q.push_back(e);
            if (!resp || (d - 2 > t)) begin
                exp_err = 1'b1;
                exp_end = e + 2 + t;
                return;
            end
            w = e + d;
            if (m != 0 && i == m) begin
                exp_end = w;
                return;
            end
            e = next_phase(w + g + 2, trig);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        if (test_enable_re === 1'b1) begin
            pulses.push_back(edge_n);
            if (resp_en) begin
                armed   = 1'b1;
                drop_at = edge_n + drop_dly;
                rise_at = edge_n + resp_dly;
            end
        end
        if (sm_loop_state == DONE_LC && done_edge < 0) done_edge = edge_n;
        if (sm_loop_state == ERROR_LC && err_edge < 0) err_edge = edge_n;
        clk_counter = 6'((edge_n + 1) % 64);
        if (armed) begin
            if (edge_n + 1 == rise_at) begin
                tsd   = 1'b1;
                armed = 1'b0;
            end else if (edge_n + 1 >= drop_at) begin
                tsd = 1'b0;
            end
        end
        test_status_done = tsd;
        start = busy_start && (sm_loop_state == WAIT_DONE_LC);
    endtask

    task automatic cfg(input int m, input int g, input int tp, input int d, input int t,
                       input int drop, input bit resp);
        loop_count_max   = 16'(m);
        loop_gap         = 16'(g);
        trig_phase       = 6'(tp);
        timeout_max      = 20'(t);
        resp_dly         = d;
        drop_dly         = drop;
        resp_en          = resp;
        armed            = 1'b0;
        if (!resp) tsd = 1'b0;
        test_status_done = tsd;
        pulses.delete();
        done_edge = -1;
        err_edge  = -1;
    endtask

    task automatic run_and_check(input string tag, input int m, input int g, input int tp,
                                 input int d, input int t, input int drop, input bit resp);
        bit reached;
        int exp_cnt;
        cfg(m, g, tp, d, t, drop, resp);
        predict(edge_n + 1, m, g, tp, d, t, resp, m);
        start = 1'b1;
        tick();
        reached = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (sm_loop_state == IDLE_LC || sm_loop_state == ERROR_LC) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_reach"}, 32'(reached), 32'd1);
        check({tag, "_npulse"}, pulses.size(), exp_q.size());
        for (int i = 0; i < pulses.size() && i < exp_q.size(); i++) begin
            check({tag, "_edge"}, pulses[i], exp_q[i]);
            check({tag, "_phase"}, pulses[i] % 64, tp);
        end
        exp_cnt = exp_err ? exp_q.size() - 1 : m;
        check({tag, "_end"}, exp_err ? err_edge : done_edge, exp_end);
        check({tag, "_state"}, 32'(sm_loop_state), exp_err ? 32'(ERROR_LC) : 32'(IDLE_LC));
        check({tag, "_count"}, 32'(loop_count), exp_cnt);
        check({tag, "_sdone"}, 32'(loop_status_done), 32'(!exp_err));
        check({tag, "_stmo"}, 32'(loop_status_timeout), 32'(exp_err));
        check({tag, "_busy"}, 32'(loop_busy), 32'd0);
        if (exp_err) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check({tag, "_abort_state"}, 32'(sm_loop_state), 32'(IDLE_LC));
            check({tag, "_abort_tmo"}, 32'(loop_status_timeout), 32'd1);
            check({tag, "_abort_count"}, 32'(loop_count), exp_cnt);
        end
    endtask

    initial begin
        int  m;
        int  g;
        int  tp;
        int  d;
        int  t;
        bit  reached;
        reset = 1'b1; enable = 1'b1; start = 1'b0; abort = 1'b0;
        tsd = 1'b0; test_status_done = 1'b0; clk_counter = 6'd1;
        trig_phase = '0; loop_count_max = '0; loop_gap = '0; timeout_max = '0;
        resp_en = 1'b0; armed = 1'b0; busy_start = 1'b1;
        drop_dly = 1; resp_dly = 2; drop_at = 0; rise_at = 0;
        done_edge = -1; err_edge = -1;

        repeat (3) tick();
        check("rst_state", 32'(sm_loop_state), 32'(IDLE_LC));
        check("rst_te", 32'(test_enable_re), 32'd0);
        check("rst_busy", 32'(loop_busy), 32'd0);
        check("rst_count", 32'(loop_count), 32'd0);
        check("rst_sdone", 32'(loop_status_done), 32'd0);
        check("rst_stmo", 32'(loop_status_timeout), 32'd0);
        reset = 1'b0;
        tick();

        run_and_check("base", 3, 10, 5, 50, 1000, 1, 1);

        // Done stays high across the launch and well into WAIT_DONE before the 1->0->1.
        armed = 1'b0; tsd = 1'b1; test_status_done = 1'b1;
        repeat (4) tick();
        run_and_check("held", 1, 0, 17, 20, 500, 6, 1);

        run_and_check("tmo100", 2, 4, 33, 0, 100, 1, 0);
        start = 1'b1;
        tick();
        check("restart_tmo", 32'(loop_status_timeout), 32'd0);
        check("restart_count", 32'(loop_count), 32'd0);
        check("restart_state", 32'(sm_loop_state), 32'(ALIGN_LC));
        // Abort lands on the phase-match edge: no launch may follow.
        trig_phase = 6'((edge_n + 1) % 64);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_match_te", 32'(test_enable_re), 32'd0);
        check("abort_match_state", 32'(sm_loop_state), 32'(IDLE_LC));

        for (int r = 0; r < 6; r++) begin
            m  = $urandom_range(1, 3);
            g  = $urandom_range(0, 15);
            tp = $urandom_range(0, 63);
            d  = $urandom_range(3, 40);
            case (r % 3)
                0:       t = d - 2;
                1:       t = $urandom_range(d - 2, 300);
                default: t = (r == 2) ? 0 : d - 3;
            endcase
            run_and_check($sformatf("rnd%0d", r), m, g, tp, d, t, 1, 1);
        end

        tp = $urandom_range(0, 63);
        cfg(0, 3, tp, 15, 1000, 1, 1);
        predict(edge_n + 1, 0, 3, tp, 15, 1000, 1, 5);
        start = 1'b1;
        tick();
        reached = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (loop_count == 16'd5) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        check("inf_reach", 32'(reached), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("inf_npulse", pulses.size(), exp_q.size());
        for (int i = 0; i < pulses.size() && i < exp_q.size(); i++) begin
            check("inf_edge", pulses[i], exp_q[i]);
        end
        check("inf_state", 32'(sm_loop_state), 32'(IDLE_LC));
        check("inf_count", 32'(loop_count), 32'd5);
        check("inf_sdone", 32'(loop_status_done), 32'd0);
        check("inf_busy", 32'(loop_busy), 32'd0);
        pulses.delete();
        repeat (150) tick();
        check("inf_quiet", pulses.size(), 32'd0);

        start = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("startabort_state", 32'(sm_loop_state), 32'(IDLE_LC));
        check("startabort_busy", 32'(loop_busy), 32'd0);
        check("startabort_count", 32'(loop_count), 32'd5);

        for (int k = 0; k < 2; k++) begin
            cfg(3, 20, $urandom_range(0, 63), 10, 1000, 1, 1);
            start = 1'b1;
            tick();
            reached = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                if (loop_count == 16'd1 &&
                    sm_loop_state == ((k == 0) ? GAP_LC : WAIT_DONE_LC)) begin
                    reached = 1'b1;
                    break;
                end
                tick();
            end
            check($sformatf("kill%0d_reach", k), 32'(reached), 32'd1);
            if (k == 0) enable = 1'b0;
            else        reset  = 1'b1;
            tick();
            enable = 1'b1;
            reset  = 1'b0;
            check($sformatf("kill%0d_state", k), 32'(sm_loop_state), 32'(IDLE_LC));
            check($sformatf("kill%0d_te", k), 32'(test_enable_re), 32'd0);
            check($sformatf("kill%0d_busy", k), 32'(loop_busy), 32'd0);
            check($sformatf("kill%0d_count", k), 32'(loop_count), 32'd0);
            check($sformatf("kill%0d_sdone", k), 32'(loop_status_done), 32'd0);
            check($sformatf("kill%0d_stmo", k), 32'(loop_status_timeout), 32'd0);
            pulses.delete();
            repeat (150) tick();
            check($sformatf("kill%0d_quiet", k), pulses.size(), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
        $finish;
    end

endmodule
